// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with scan-level debounce
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    logic [SW-1:0] slot;
    logic [1:0]    col_idx;
    logic          slot_last;
    logic          scan_end;
    logic [3:0]    rows_s1;
    logic [3:0]    rows_s2;
    logic [15:0]   snapshot;
    logic [15:0]   col_bits;
    logic [15:0]   full_snap;
    logic [4:0]    ones;
    logic [3:0]    hit_code;
    logic          res_none;
    logic          res_one;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    cand, cand_nx;
    logic [3:0]    code_nx;
    logic          valid_nx;
    logic          held_nx;

    assign slot_last = (slot == SW'(SCAN_DIV - 1));
    assign scan_end  = slot_last && (col_idx == 2'd3);

    // Column drive: one active-low column per slot, rotating forever
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot    <= '0;
            col_idx <= 2'd0;
            cols_n  <= 4'b1110;
        end else if (slot_last) begin
            slot    <= '0;
            col_idx <= col_idx + 2'd1;
            cols_n  <= {cols_n[2:0], cols_n[3]};
        end else begin
            slot <= slot + SW'(1);
        end
    end

    // Two-stage synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_s1 <= 4'b1111;
            rows_s2 <= 4'b1111;
        end else begin
            rows_s1 <= rows_n;
            rows_s2 <= rows_s1;
        end
    end

    // Place the current column's pressed rows at bit r*4+c
    always_comb begin
        col_bits = '0;
        for (int r = 0; r < 4; r++) begin
            col_bits[r*4 + int'(col_idx)] = ~rows_s2[r];
        end
        full_snap = snapshot | col_bits;
    end

    // Accumulate one full scan; cleared as the last column is folded in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot <= '0;
        end else if (slot_last) begin
            snapshot <= scan_end ? '0 : full_snap;
        end
    end

    // Classify the completed scan: number of keys down and the code of one of them
    always_comb begin
        ones     = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (full_snap[i]) begin
                ones     = ones + 5'd1;
                hit_code = 4'(i);
            end
        end
        res_none = (ones == 5'd0);
        res_one  = (ones == 5'd1);
    end

    // Debounce FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cand      <= cand_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
        end
    end

    // Next-state logic, only advanced on scan end; key_valid is a single-clock pulse
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        code_nx  = key_code;
        valid_nx = 1'b0;
        held_nx  = key_held;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (res_one) begin
                        cand_nx = hit_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_nx = HELD;
                            cnt_nx   = '0;
                            code_nx  = hit_code;
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                        end else begin
                            state_nx = DEBOUNCE;
                            cnt_nx   = CW'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (res_one && hit_code == cand) begin
                        if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                            state_nx = HELD;
                            cnt_nx   = '0;
                            code_nx  = cand;
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                HELD: begin
                    if (res_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                            held_nx  = 1'b0;
                        end else begin
                            state_nx = RELEASE;
                            cnt_nx   = CW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (res_none) begin
                        if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                            held_nx  = 1'b0;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end else begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized self-checking bench for keypad_scanner
module tb_keypad_scanner;

    localparam int DS    = 3;
    localparam int BOUND = (DS + 1) * 4 * 4 + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = '0;
    int checks = 0;
    int errors = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DS)) dut (
        .clk      (clk),
        .rst      (rst),
        .rows_n   (rows_n),
        .cols_n   (cols_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when that column is driven low
    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !cols_n[c]) rows_n[r] = 1'b0;
    end

    // Reference model: clocks since reset fix which column is sampled; each completed scan is a
    // set of keys, and a press/release is accepted after DS consecutive qualifying scans
    int          m_cnt = 0;
    int          m_run = 0;
    bit          m_held = 1'b0;
    logic [3:0]  m_cand = '0;
    logic [15:0] m_snap = '0;
    logic [3:0]  exp_cols = 4'b1110;
    logic [3:0]  exp_code = '0;
    logic        exp_held = 1'b0;
    logic        exp_valid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_run = 0; m_held = 1'b0; m_cand = '0; m_snap = '0;
            exp_cols = 4'b1110; exp_code = '0; exp_held = 1'b0; exp_valid = 1'b0;
        end else begin
            int n;
            logic [3:0] code;
            m_cnt++;
            exp_valid = 1'b0;
            if (m_cnt % 4 == 2) begin
                int c;
                c = (m_cnt % 16) / 4;
                for (int r = 0; r < 4; r++) m_snap[r*4 + c] = pressed[r*4 + c];
            end
            if (m_cnt % 16 == 0) begin
                n = $countones(m_snap);
                code = '0;
                for (int i = 0; i < 16; i++) if (m_snap[i]) code = 4'(i);
                if (!m_held) begin
                    if (m_run > 0) begin
                        if (n == 1 && code == m_cand) m_run++; else m_run = 0;
                    end else if (n == 1) begin
                        m_cand = code; m_run = 1;
                    end
                    if (m_run == DS) begin
                        m_held = 1'b1; m_run = 0; exp_valid = 1'b1; exp_code = m_cand;
                    end
                end else begin
                    if (n == 0) m_run++; else m_run = 0;
                    if (m_run == DS) begin m_held = 1'b0; m_run = 0; end
                end
                exp_held = m_held;
                m_snap = '0;
            end
            exp_cols = ~(4'b0001 << ((m_cnt / 4) % 4));
        end
    end

    wire [9:0] obs  = {cols_n, key_code, key_held, key_valid};
    wire [9:0] want = {exp_cols, exp_code, exp_held, exp_valid};

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 10'b1110_0000_0_0) begin
            errors++; $display("FAIL reset_state got %b want %b", obs, 10'b1110_0000_0_0);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int pulses = 0;
        pressed = '0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL idle_cycle t=%0t got %b want %b", $time, obs, want); end
            if (key_valid || key_held) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL idle_activity got %0d want 0", pulses); end
    endtask

    task automatic test_single_key();
        int lat = -1;
        int pulses = 0;
        pressed = 16'h0200;
        for (int i = 1; i <= BOUND; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL single_cycle t=%0t got %b want %b", $time, obs, want); end
            if (key_valid) begin pulses++; if (lat < 0) lat = i; end
        end
        checks++;
        if (lat < 0) begin errors++; $display("FAIL single_latency got none want <=%0d", BOUND); end
        checks++;
        if (key_code !== 4'h9) begin errors++; $display("FAIL single_code got %h want 9", key_code); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL single_hold t=%0t got %b want %b", $time, obs, want); end
            if (key_valid) pulses++;
        end
        checks++;
        if (key_held !== 1'b1 || pulses !== 1) begin
            errors++; $display("FAIL single_held got held=%b pulses=%0d want 1/1", key_held, pulses);
        end
        pressed = '0;
        lat = -1;
        for (int i = 1; i <= BOUND; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL single_release t=%0t got %b want %b", $time, obs, want); end
            if (!key_held && lat < 0) lat = i;
        end
        checks++;
        if (lat < 0) begin errors++; $display("FAIL single_release_latency got held=%b want 0", key_held); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int guard = 0;
        pressed = '0;
        repeat (60) @(negedge clk);
        while (m_cnt % 16 != 10 && guard < 32) begin @(negedge clk); guard++; end
        for (int i = 0; i < 300; i++) begin
            pressed = ((i / 10) % 2 == 0) ? 16'h0040 : 16'h0000;
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL bounce_cycle t=%0t got %b want %b", $time, obs, want); end
            if (key_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL bounce_no_valid got %0d want 0", pulses); end
        pressed = 16'h0040;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL bounce_stable t=%0t got %b want %b", $time, obs, want); end
            if (key_valid) pulses++;
        end
        checks++;
        if (pulses !== 1 || key_code !== 4'h6) begin
            errors++; $display("FAIL bounce_accept got pulses=%0d code=%h want 1/6", pulses, key_code);
        end
        pressed = '0;
        repeat (80) @(negedge clk);
    endtask

    task automatic test_multi_key();
        int pulses = 0;
        pressed = 16'h0021;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL multi_cycle t=%0t got %b want %b", $time, obs, want); end
            if (key_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL multi_no_valid got %0d want 0", pulses); end
        pressed = 16'h0020;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL multi_single t=%0t got %b want %b", $time, obs, want); end
            if (key_valid) pulses++;
        end
        checks++;
        if (pulses !== 1 || key_code !== 4'h5) begin
            errors++; $display("FAIL multi_accept got pulses=%0d code=%h want 1/5", pulses, key_code);
        end
        pressed = '0;
        repeat (80) @(negedge clk);
    endtask

    task automatic test_second_key_held();
        int pulses = 0;
        int lat = -1;
        pressed = 16'h0008;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL second_press t=%0t got %b want %b", $time, obs, want); end
        end
        pressed = 16'h1008;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL second_both t=%0t got %b want %b", $time, obs, want); end
            if (key_valid) pulses++;
        end
        checks++;
        if (pulses !== 0 || key_code !== 4'h3 || key_held !== 1'b1) begin
            errors++; $display("FAIL second_ignored got pulses=%0d code=%h held=%b want 0/3/1", pulses, key_code, key_held);
        end
        pressed = '0;
        for (int i = 1; i <= BOUND; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL second_release t=%0t got %b want %b", $time, obs, want); end
            if (!key_held && lat < 0) lat = i;
        end
        checks++;
        if (lat < 0 || key_code !== 4'h3) begin
            errors++; $display("FAIL second_release_done got held=%b code=%h want 0/3", key_held, key_code);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        pressed = 16'h8000;
        for (int i = 0; i < BOUND + 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL rstmid_press t=%0t got %b want %b", $time, obs, want); end
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 10'b1110_0000_0_0) begin errors++; $display("FAIL rstmid_async got %b want %b", obs, 10'b1110_0000_0_0); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < BOUND + 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL rstmid_redo t=%0t got %b want %b", $time, obs, want); end
            if (key_valid) pulses++;
        end
        checks++;
        if (pulses !== 1 || key_code !== 4'hF) begin
            errors++; $display("FAIL rstmid_accept got pulses=%0d code=%h want 1/f", pulses, key_code);
        end
        pressed = '0;
        repeat (80) @(negedge clk);
    endtask

    task automatic test_random();
        for (int p = 0; p < 50; p++) begin
            int kind;
            int dur;
            kind = $urandom_range(0, 3);
            dur  = $urandom_range(5, 90);
            case (kind)
                0:       pressed = '0;
                1, 2:    pressed = 16'h0001 << $urandom_range(0, 15);
                default: pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            endcase
            for (int i = 0; i < dur; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== want) begin errors++; $display("FAIL random_cycle t=%0t got %b want %b", $time, obs, want); end
            end
        end
        pressed = '0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_second_key_held();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
